// File: rtl/axis_stream_pkg.sv
// Shared defaults and master state encoding for the AXI4-Stream source/sink pair.
package axis_stream_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int PKT_LEN_DEF = 40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/axis_stream_rx.sv
// Stream slave: exposes rx_ready as tready and captures every accepted beat.
module axis_stream_rx
    import axis_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic              rx_ready,
    input  logic              tvalid,
    input  logic              tlast,
    input  logic [DATA_W-1:0] tdata,
    output logic              tready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_finish
);

    logic handshake;

    assign tready    = rx_ready;
    assign handshake = tvalid && rx_ready;

    always_ff @(posedge aclk) begin
        if (areset_n) begin
            rx_data   <= '0;
            rx_finish <= 1'b0;
        end else begin
            rx_finish <= handshake && tlast;
            if (handshake) begin
                rx_data <= tdata;
            end
        end
    end

endmodule

// File: rtl/axis_stream_tx.sv
// Stream master: turns a send pulse into one PKT_LEN-beat packet counting up from a latched base word.
module axis_stream_tx
    import axis_stream_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PKT_LEN = PKT_LEN_DEF
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              send,
    input  logic              tready,
    output logic              tvalid,
    output logic              tlast,
    output logic [DATA_W-1:0] tdata,
    output logic              tx_finish
);

    localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_LEN - 1);

    tx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic              tvalid_d, tlast_d, tx_finish_d;
    logic [DATA_W-1:0] tdata_d;
    logic              handshake;

    assign handshake = tvalid && tready;

    // areset_n is active-high despite its name; outputs are registered next to the state.
    always_ff @(posedge aclk) begin
        if (areset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            base_q    <= '0;
            tvalid    <= 1'b0;
            tlast     <= 1'b0;
            tdata     <= '0;
            tx_finish <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            tvalid    <= tvalid_d;
            tlast     <= tlast_d;
            tdata     <= tdata_d;
            tx_finish <= tx_finish_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        unique case (state_q)
            IDLE: begin
                if (send) begin
                    state_d = SEND;
                    cnt_d   = '0;
                    base_d  = tx_data;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (tlast) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values are derived from the upcoming state so they land in registers alongside it.
    always_comb begin
        tvalid_d    = (state_d == SEND);
        tlast_d     = (state_d == SEND) && (cnt_d == LAST_CNT);
        tx_finish_d = (state_d == DONE);
        tdata_d     = tdata;
        if (state_d == SEND) begin
            tdata_d = base_d + DATA_W'(cnt_d);
        end
    end

endmodule

// File: rtl/axis_stream_pair.sv
// Loopback of a stream master into a stream slave, with the link signals exported for observation.
module axis_stream_pair
    import axis_stream_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PKT_LEN = PKT_LEN_DEF
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              send,
    input  logic              rx_ready,
    output logic              tvalid,
    output logic              tready,
    output logic              tlast,
    output logic [DATA_W-1:0] tdata,
    output logic              tx_finish,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_finish
);

    axis_stream_tx #(
        .DATA_W  (DATA_W),
        .PKT_LEN (PKT_LEN)
    ) u_tx (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .tx_data   (tx_data),
        .send      (send),
        .tready    (tready),
        .tvalid    (tvalid),
        .tlast     (tlast),
        .tdata     (tdata),
        .tx_finish (tx_finish)
    );

    axis_stream_rx #(
        .DATA_W (DATA_W)
    ) u_rx (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .rx_ready  (rx_ready),
        .tvalid    (tvalid),
        .tlast     (tlast),
        .tdata     (tdata),
        .tready    (tready),
        .rx_data   (rx_data),
        .rx_finish (rx_finish)
    );

endmodule

// File: tb/tb_axis_stream_pair.sv
// Directed self-checking bench for axis_stream_pair with a negedge beat monitor.
module tb_axis_stream_pair;

    localparam int DW = 32;
    localparam int PL = 40;

    logic          aclk;
    logic          areset_n;
    logic [DW-1:0] tx_data;
    logic          send;
    logic          rx_ready;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic [DW-1:0] tdata;
    logic          tx_finish;
    logic [DW-1:0] rx_data;
    logic          rx_finish;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] beat_q[$];
    bit            last_q[$];
    int            txf_cnt = 0;
    int            rxf_cnt = 0;

    axis_stream_pair #(
        .DATA_W  (DW),
        .PKT_LEN (PL)
    ) dut (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .tx_data   (tx_data),
        .send      (send),
        .rx_ready  (rx_ready),
        .tvalid    (tvalid),
        .tready    (tready),
        .tlast     (tlast),
        .tdata     (tdata),
        .tx_finish (tx_finish),
        .rx_data   (rx_data),
        .rx_finish (rx_finish)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Inputs only change just after a rising edge, so the negedge view predicts the next edge's handshake.
    always @(negedge aclk) begin
        if (!areset_n) begin
            if (tvalid && tready) begin
                beat_q.push_back(tdata);
                last_q.push_back(tlast);
            end
            if (tx_finish) txf_cnt++;
            if (rx_finish) rxf_cnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic [DW-1:0] d);
        send     = s;
        rx_ready = r;
        tx_data  = d;
        @(posedge aclk);
        #1;
    endtask

    task automatic runPacket(input logic [DW-1:0] base, input logic [DW-1:0] late_data,
                             input bit toggle, input bit poke, output int cycles);
        bit done = 1'b0;
        cycles = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            applyStimulus(poke && (i % 6 == 3), toggle ? (i % 2 == 0) : 1'b1,
                          (i >= 5) ? late_data : base);
            cycles++;
            if (tx_finish) done = 1'b1;
        end
        checkOutput("finish_seen", 32'(done), 32'd1);
    endtask

    task automatic checkPacket(input string tag, input int start, input logic [DW-1:0] base, input int n);
        int errs     = 0;
        int lasts    = 0;
        int last_pos = -1;
        checkOutput({tag, "_beats"}, 32'(beat_q.size() - start), 32'(n));
        for (int i = start; i < beat_q.size(); i++) begin
            if (beat_q[i] !== base + 32'(i - start)) errs++;
            if (last_q[i]) begin
                lasts++;
                last_pos = i - start;
            end
        end
        checkOutput({tag, "_order"}, 32'(errs), 32'd0);
        checkOutput({tag, "_tlast_cnt"}, 32'(lasts), 32'd1);
        checkOutput({tag, "_tlast_pos"}, 32'(last_pos), 32'(n - 1));
    endtask

    initial begin
        int cyc;
        int mark;
        int txf0;
        int rxf0;

        areset_n = 1'b1;
        send     = 1'b0;
        rx_ready = 1'b1;
        tx_data  = '0;

        // Reset held for 4 cycles
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 32'h0);
        checkOutput("rst_tvalid", 32'(tvalid), 32'd0);
        checkOutput("rst_tlast", 32'(tlast), 32'd0);
        checkOutput("rst_tdata", tdata, 32'h0);
        checkOutput("rst_tx_finish", 32'(tx_finish), 32'd0);
        checkOutput("rst_rx_data", rx_data, 32'h0);
        checkOutput("rst_rx_finish", 32'(rx_finish), 32'd0);
        checkOutput("rst_tready", 32'(tready), 32'd1);
        areset_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h0);

        // Basic packet
        mark = beat_q.size();
        txf0 = txf_cnt;
        rxf0 = rxf_cnt;
        applyStimulus(1'b1, 1'b1, 32'hAAAA_BBBB);
        checkOutput("basic_tvalid_rise", 32'(tvalid), 32'd1);
        checkOutput("basic_first_tdata", tdata, 32'hAAAA_BBBB);
        checkOutput("basic_first_tlast", 32'(tlast), 32'd0);
        runPacket(32'hAAAA_BBBB, 32'hAAAA_BBBB, 1'b0, 1'b0, cyc);
        checkOutput("basic_latency", 32'(cyc), 32'd40);
        checkOutput("basic_tx_finish", 32'(tx_finish), 32'd1);
        checkOutput("basic_rx_finish", 32'(rx_finish), 32'd1);
        checkOutput("basic_rx_data", rx_data, 32'hAAAA_BBE2);
        applyStimulus(1'b0, 1'b1, 32'hAAAA_BBBB);
        checkOutput("basic_tx_finish_drop", 32'(tx_finish), 32'd0);
        checkOutput("basic_rx_finish_drop", 32'(rx_finish), 32'd0);
        checkOutput("basic_tvalid_drop", 32'(tvalid), 32'd0);
        checkPacket("basic", mark, 32'hAAAA_BBBB, 40);
        checkOutput("basic_tx_pulses", 32'(txf_cnt - txf0), 32'd1);
        checkOutput("basic_rx_pulses", 32'(rxf_cnt - rxf0), 32'd1);

        // Backpressure after 16 accepted beats
        mark = beat_q.size();
        txf0 = txf_cnt;
        applyStimulus(1'b1, 1'b1, 32'hAAAA_BBBB);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 32'hAAAA_BBBB);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'hAAAA_BBBB);
        checkOutput("bp_beats", 32'(beat_q.size() - mark), 32'd16);
        checkOutput("bp_rx_data", rx_data, 32'hAAAA_BBCA);
        checkOutput("bp_tvalid_held", 32'(tvalid), 32'd1);
        checkOutput("bp_tdata_frozen", tdata, 32'hAAAA_BBCB);
        checkOutput("bp_tready", 32'(tready), 32'd0);
        checkOutput("bp_no_finish", 32'(txf_cnt - txf0), 32'd0);
        runPacket(32'hAAAA_BBBB, 32'hAAAA_BBBB, 1'b0, 1'b0, cyc);
        checkOutput("bp_resume_latency", 32'(cyc), 32'd24);
        checkOutput("bp_rx_data_end", rx_data, 32'hAAAA_BBE2);
        applyStimulus(1'b0, 1'b1, 32'hAAAA_BBBB);
        checkPacket("bp", mark, 32'hAAAA_BBBB, 40);

        // Mid-packet data change plus send pulses during SEND and DONE
        mark = beat_q.size();
        txf0 = txf_cnt;
        applyStimulus(1'b1, 1'b1, 32'hAAAA_BBBB);
        runPacket(32'hAAAA_BBBB, 32'hCCCC_DDDD, 1'b0, 1'b1, cyc);
        checkOutput("busy_latency", 32'(cyc), 32'd40);
        applyStimulus(1'b1, 1'b1, 32'hCCCC_DDDD);
        checkOutput("busy_done_send_ignored", 32'(tvalid), 32'd0);
        checkPacket("busy", mark, 32'hAAAA_BBBB, 40);
        checkOutput("busy_tx_pulses", 32'(txf_cnt - txf0), 32'd1);

        mark = beat_q.size();
        applyStimulus(1'b1, 1'b1, 32'hCCCC_DDDD);
        runPacket(32'hCCCC_DDDD, 32'hCCCC_DDDD, 1'b0, 1'b0, cyc);
        checkOutput("newbase_rx_data", rx_data, 32'hCCCC_DE04);
        applyStimulus(1'b0, 1'b1, 32'hCCCC_DDDD);
        checkPacket("newbase", mark, 32'hCCCC_DDDD, 40);

        // One-cycle reset in the middle of a packet
        txf0 = txf_cnt;
        rxf0 = rxf_cnt;
        applyStimulus(1'b1, 1'b1, 32'h1234_0000);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 32'h1234_0000);
        areset_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h1234_0000);
        areset_n = 1'b0;
        checkOutput("mrst_tvalid", 32'(tvalid), 32'd0);
        checkOutput("mrst_rx_data", rx_data, 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 32'h1234_0000);
        checkOutput("mrst_stays_idle", 32'(tvalid), 32'd0);
        checkOutput("mrst_no_tx_finish", 32'(txf_cnt - txf0), 32'd0);
        checkOutput("mrst_no_rx_finish", 32'(rxf_cnt - rxf0), 32'd0);
        mark = beat_q.size();
        applyStimulus(1'b1, 1'b1, 32'h5555_0000);
        checkOutput("mrst_new_send", 32'(tvalid), 32'd1);
        runPacket(32'h5555_0000, 32'h5555_0000, 1'b0, 1'b0, cyc);
        applyStimulus(1'b0, 1'b1, 32'h5555_0000);
        checkPacket("mrst", mark, 32'h5555_0000, 40);

        // rx_ready toggling every cycle
        mark = beat_q.size();
        rxf0 = rxf_cnt;
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FFF0);
        runPacket(32'hFFFF_FFF0, 32'hFFFF_FFF0, 1'b1, 1'b0, cyc);
        checkOutput("stall_latency", 32'(cyc), 32'd79);
        checkOutput("stall_rx_data", rx_data, 32'h0000_0017);
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF0);
        checkPacket("stall", mark, 32'hFFFF_FFF0, 40);
        checkOutput("stall_rx_pulses", 32'(rxf_cnt - rxf0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
